// File: rtl/cga_intr_pkg.sv
// Shared types for the CGA interrupt IDENT responder.
// Optional feature macro: CGA_INTR_ROUND_ROBIN_EN (rotating winner pointer).
package cga_intr_pkg;

   localparam int LVL_W = 4;
   localparam int IDC_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PASS,
      ST_LATCH,
      ST_DRIVE,
      ST_DONE
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cga_intr_prio_pick.sv
// Pending-vector winner picker: first set bit at or above ptr, wrapping.
// With ptr tied to 0 this is plain lowest-index priority.
module cga_intr_prio_pick #(
   parameter int NSRC = 4,
   parameter int IW   = 2
) (
   input  logic [NSRC-1:0] pend,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [NSRC-1:0] rot;
   logic [IW:0]     sum;

   always_comb begin
      rot = NSRC'({pend, pend} >> ptr);
      any = 1'b0;
      sum = '0;
      // Scan downward so the lowest rotated position is the last one kept.
      for (int k = NSRC - 1; k >= 0; k--) begin
         if (rot[k]) begin
            any = 1'b1;
            sum = {1'b0, ptr} + (IW+1)'(k);
         end
      end
      if (sum >= (IW+1)'(NSRC)) begin
         sum = sum - (IW+1)'(NSRC);
      end
      idx = sum[IW-1:0];
   end

endmodule

// File: rtl/cga_intr_ident_responder.sv
// Level interrupt requester and IDENT responder for one CGA level.
// Define CGA_INTR_ROUND_ROBIN_EN for rotating source priority.
module cga_intr_ident_responder
   import cga_intr_pkg::*;
#(
   parameter int               NSRC   = 4,
   parameter logic [LVL_W-1:0] LEVEL  = 4'd11,
   parameter logic [IDC_W-1:0] IDBASE = 8'h00
) (
   input  logic             MCLK,
   input  logic             RESETN,
   input  logic [NSRC-1:0]  SRC_REQ,
   input  logic [NSRC-1:0]  SRC_CLR,
   input  logic             ENABLE,
   input  logic             IDENT,
   input  logic [LVL_W-1:0] IDLEV,
   input  logic             PI,
   output logic             PO,
   output logic             INTRQ,
   output logic             IDVALID,
   output logic [IDC_W-1:0] IDCODE,
   output logic [NSRC-1:0]  PEND,
   output logic [NSRC-1:0]  SERVED
);

   localparam int IW = idx_w(NSRC);

   state_t          state;
   state_t          state_nxt;
   logic [NSRC-1:0] req_q;
   logic [NSRC-1:0] pend_q;
   logic [NSRC-1:0] pend_nxt;
   logic [NSRC-1:0] served_q;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] retire;
   logic            intrq_q;
   logic [IW-1:0]   win_q;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   ptr;
   logic            pick_any;
   logic            lvl_hit;
   logic            claim;
   logic            capture;

   cga_intr_prio_pick #(
      .NSRC (NSRC),
      .IW   (IW)
   ) u_pick (
      .pend (pend_q),
      .ptr  (ptr),
      .idx  (pick_idx),
      .any  (pick_any)
   );

`ifdef CGA_INTR_ROUND_ROBIN_EN
   logic [IW-1:0] ptr_q;

   always_ff @(posedge MCLK or negedge RESETN) begin
      if (!RESETN) begin
         ptr_q <= '0;
      end else if (state == ST_DONE) begin
         ptr_q <= (win_q == IW'(NSRC - 1)) ? '0 : win_q + 1'b1;
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   assign lvl_hit = (IDLEV == LEVEL);
   assign claim   = IDENT & lvl_hit & PI & ENABLE & pick_any;
   assign rise    = SRC_REQ & ~req_q;

   always_comb begin
      retire = '0;
      if (state == ST_DONE) begin
         retire[win_q] = 1'b1;
      end
   end

   // A fresh request edge overrides any clear landing in the same cycle.
   assign pend_nxt = (pend_q & ~SRC_CLR & ~retire) | rise;

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      PO        = 1'b0;
      unique case (state)
         ST_IDLE: begin
            PO = PI & ~claim;
            if (claim) begin
               state_nxt = ST_LATCH;
               capture   = 1'b1;
            end else if (IDENT && lvl_hit) begin
               state_nxt = ST_PASS;
            end
         end
         ST_PASS: begin
            PO = PI;
            if (!IDENT) state_nxt = ST_IDLE;
         end
         ST_LATCH: begin
            state_nxt = IDENT ? ST_DRIVE : ST_IDLE;
         end
         ST_DRIVE: begin
            if (!IDENT) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge MCLK or negedge RESETN) begin
      if (!RESETN) begin
         state    <= ST_IDLE;
         req_q    <= '0;
         pend_q   <= '0;
         served_q <= '0;
         intrq_q  <= 1'b0;
         win_q    <= '0;
      end else begin
         state    <= state_nxt;
         req_q    <= SRC_REQ;
         pend_q   <= pend_nxt;
         served_q <= retire;
         intrq_q  <= ENABLE & (|pend_q);
         if (capture) win_q <= pick_idx;
      end
   end

   assign IDVALID = (state == ST_DRIVE);
   assign IDCODE  = IDVALID ? IDBASE + IDC_W'(win_q) : '0;
   assign PEND    = pend_q;
   assign SERVED  = served_q;
   assign INTRQ   = intrq_q;

endmodule

// File: tb/tb_cga_intr_ident_responder.sv
// Directed bench for cga_intr_ident_responder with a protocol-level model.
// Model expectations track CGA_INTR_ROUND_ROBIN_EN when it is defined.
module tb_cga_intr_ident_responder;

   localparam int         NSRC   = 4;
   localparam logic [3:0] LEVEL  = 4'd11;
   localparam logic [7:0] IDBASE = 8'h00;

   logic            MCLK = 1'b0;
   logic            RESETN = 1'b0;
   logic [NSRC-1:0] SRC_REQ = '0;
   logic [NSRC-1:0] SRC_CLR = '0;
   logic            ENABLE = 1'b0;
   logic            IDENT = 1'b0;
   logic [3:0]      IDLEV = '0;
   logic            PI = 1'b1;
   logic            PO;
   logic            INTRQ;
   logic            IDVALID;
   logic [7:0]      IDCODE;
   logic [NSRC-1:0] PEND;
   logic [NSRC-1:0] SERVED;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 MCLK = ~MCLK;

   cga_intr_ident_responder #(
      .NSRC   (NSRC),
      .LEVEL  (LEVEL),
      .IDBASE (IDBASE)
   ) dut (
      .MCLK    (MCLK),
      .RESETN  (RESETN),
      .SRC_REQ (SRC_REQ),
      .SRC_CLR (SRC_CLR),
      .ENABLE  (ENABLE),
      .IDENT   (IDENT),
      .IDLEV   (IDLEV),
      .PI      (PI),
      .PO      (PO),
      .INTRQ   (INTRQ),
      .IDVALID (IDVALID),
      .IDCODE  (IDCODE),
      .PEND    (PEND),
      .SERVED  (SERVED)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   // Protocol model: phase 0 idle, 1 passing, 2 winner latched,
   // 3 code on the bus, 4 retiring.
   logic [NSRC-1:0] m_pend = '0;
   logic [NSRC-1:0] m_prev = '0;
   logic [NSRC-1:0] m_served = '0;
   logic            m_intrq = 1'b0;
   int              m_ph = 0;
   int              m_win = 0;
   int              m_ptr = 0;

   function automatic int pick(input logic [NSRC-1:0] p, input int base);
      for (int k = 0; k < NSRC; k++) begin
         if (p[(base + k) % NSRC]) return (base + k) % NSRC;
      end
      return 0;
   endfunction

   function automatic bit m_claim();
      return IDENT && (IDLEV == LEVEL) && PI && ENABLE && (m_pend != '0);
   endfunction

   always @(posedge MCLK or negedge RESETN) begin
      if (!RESETN) begin
         m_pend = '0; m_prev = '0; m_served = '0;
         m_intrq = 1'b0; m_ph = 0; m_win = 0; m_ptr = 0;
      end else begin : upd
         logic [NSRC-1:0] rise, ret;
         bit cl;
         rise = SRC_REQ & ~m_prev;
         ret = '0;
         if (m_ph == 4) ret[m_win] = 1'b1;
         cl = m_claim();
         m_intrq = ENABLE && (m_pend != '0);
         m_served = ret;
         case (m_ph)
            0: if (cl) begin
                  m_win = pick(m_pend, m_ptr);
                  m_ph = 2;
               end else if (IDENT && IDLEV == LEVEL) m_ph = 1;
            1: if (!IDENT) m_ph = 0;
            2: m_ph = IDENT ? 3 : 0;
            3: if (!IDENT) m_ph = 4;
            default: begin
`ifdef CGA_INTR_ROUND_ROBIN_EN
               m_ptr = (m_win + 1) % NSRC;
`endif
               m_ph = 0;
            end
         endcase
         m_pend = (m_pend & ~SRC_CLR & ~ret) | rise;
         m_prev = SRC_REQ;
      end
   end

   always @(negedge MCLK) begin : cmp
      logic [7:0] ecode;
      bit ev, epo;
      if (cmp_en) begin
         ev = (m_ph == 3);
         ecode = ev ? 8'(IDBASE + m_win) : 8'h00;
         epo = (m_ph == 0) ? (PI && !m_claim()) : (m_ph == 1) ? PI : 1'b0;
         chk("m_pend", PEND, m_pend);
         chk("m_intrq", INTRQ, m_intrq);
         chk("m_idvalid", IDVALID, ev);
         chk("m_idcode", IDCODE, ecode);
         chk("m_served", SERVED, m_served);
         chk("m_po", PO, epo);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge MCLK);
      #2;
   endtask

   task automatic pulse_req(input logic [NSRC-1:0] v);
      SRC_REQ = v;
      step(1);
      SRC_REQ = '0;
      step(2);
   endtask

   task automatic ident_cycle(output logic [7:0] code, output int lat,
                              output logic [NSRC-1:0] srv,
                              input bit req0_in_done);
      code = '0;
      lat = 0;
      IDENT = 1'b1; IDLEV = LEVEL; PI = 1'b1;
      for (int i = 1; i <= 6 && lat == 0; i++) begin
         @(negedge MCLK);
         if (IDVALID) begin
            lat = i;
            code = IDCODE;
            chk("ident_po", PO, 1'b0);
         end
      end
      if (lat == 0) chk("ident_timeout", IDVALID, 1'b1);
      @(posedge MCLK); #2;
      IDENT = 1'b0;
      @(posedge MCLK); #2;
      if (req0_in_done) SRC_REQ[0] = 1'b1;
      @(posedge MCLK); #2;
      srv = SERVED;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] code;
      int lat;
      logic [NSRC-1:0] srv;

      @(posedge MCLK); #2;
      chk("rst_pend", PEND, 4'b0000);
      chk("rst_intrq", INTRQ, 1'b0);
      chk("rst_idvalid", IDVALID, 1'b0);
      chk("rst_idcode", IDCODE, 8'h00);
      chk("rst_served", SERVED, 4'b0000);
      chk("rst_po", PO, 1'b1);
      RESETN = 1'b1;
      cmp_en = 1'b1;
      step(1);

      // single source
      ENABLE = 1'b1;
      pulse_req(4'b0100);
      chk("single_pend", PEND, 4'b0100);
      chk("single_intrq", INTRQ, 1'b1);
      ident_cycle(code, lat, srv, 1'b0);
      chk("single_code", code, 8'h02);
      chk("single_latency", lat, 3);
      chk("single_served", srv, 4'b0100);
      chk("single_pend_clr", PEND, 4'b0000);
      chk("single_intrq_lag", INTRQ, 1'b1);
      step(1);
      chk("single_intrq_low", INTRQ, 1'b0);

      // priority between 1 and 3
      pulse_req(4'b1010);
      ident_cycle(code, lat, srv, 1'b0);
`ifdef CGA_INTR_ROUND_ROBIN_EN
      chk("prio_first", code, 8'h03);
`else
      chk("prio_first", code, 8'h01);
`endif
      ident_cycle(code, lat, srv, 1'b0);
`ifdef CGA_INTR_ROUND_ROBIN_EN
      chk("prio_second", code, 8'h01);
`else
      chk("prio_second", code, 8'h03);
`endif
      chk("prio_empty", PEND, 4'b0000);

      // pend 0 and 1, serve, re-pend 0
      pulse_req(4'b0011);
      ident_cycle(code, lat, srv, 1'b0);
      chk("rr_first", code, 8'h00);
      pulse_req(4'b0001);
      ident_cycle(code, lat, srv, 1'b0);
`ifdef CGA_INTR_ROUND_ROBIN_EN
      chk("rr_second", code, 8'h01);
`else
      chk("rr_second", code, 8'h00);
`endif
      SRC_CLR = '1; step(1); SRC_CLR = '0; step(1);

      // pass-through cases
      pulse_req(4'b0001);
      PI = 1'b0; IDLEV = LEVEL; IDENT = 1'b1;
      step(3);
      chk("pass_pi0_valid", IDVALID, 1'b0);
      chk("pass_pi0_po", PO, 1'b0);
      chk("pass_pi0_pend", PEND, 4'b0001);
      IDENT = 1'b0; step(1);
      PI = 1'b1; IDLEV = 4'd5; IDENT = 1'b1;
      step(3);
      chk("pass_lev_valid", IDVALID, 1'b0);
      chk("pass_lev_po", PO, 1'b1);
      chk("pass_lev_pend", PEND, 4'b0001);
      IDENT = 1'b0; SRC_CLR = 4'b0001; step(1);
      SRC_CLR = '0; step(1);
      IDLEV = LEVEL; IDENT = 1'b1;
      step(3);
      chk("pass_empty_valid", IDVALID, 1'b0);
      chk("pass_empty_po", PO, 1'b1);
      IDENT = 1'b0; step(2);

      // collisions
      SRC_REQ = 4'b0001; step(1);
      SRC_REQ = '0; step(1);
      SRC_REQ = 4'b0001; SRC_CLR = 4'b0001; step(1);
      SRC_REQ = '0; SRC_CLR = '0;
      chk("clr_collide", PEND, 4'b0001);
      step(1);
      ident_cycle(code, lat, srv, 1'b1);
      SRC_REQ = '0;
      chk("done_code", code, 8'h00);
      chk("done_served", srv, 4'b0001);
      chk("done_collide", PEND, 4'b0001);
      step(1);
      SRC_CLR = '1; step(1); SRC_CLR = '0; step(1);

      // abort in LATCH
      pulse_req(4'b0100);
      IDENT = 1'b1; IDLEV = LEVEL; PI = 1'b1;
      step(1);
      IDENT = 1'b0;
      step(1);
      chk("abort_valid", IDVALID, 1'b0);
      chk("abort_pend", PEND, 4'b0100);
      step(2);
      chk("abort_served", SERVED, 4'b0000);

      // reset while driving
      IDENT = 1'b1;
      repeat (3) @(negedge MCLK);
      chk("rst_drive_pre", IDVALID, 1'b1);
      #1 RESETN = 1'b0;
      #1;
      chk("rst_drive_valid", IDVALID, 1'b0);
      chk("rst_drive_pend", PEND, 4'b0000);
      chk("rst_drive_code", IDCODE, 8'h00);
      IDENT = 1'b0;
      @(posedge MCLK); #2;
      RESETN = 1'b1;
      step(2);
      chk("rst_drive_intrq", INTRQ, 1'b0);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cga_intr_ident_responder.md
# cga_intr_ident_responder

Device-side interrupt requester and IDENT responder for one interrupt level. It latches requests from up to NSRC local sources and raises a level request toward the CGA interrupt level logic. It answers the CPU's IDENT cycle for its level when it holds daisy-chain priority by driving the ident code of the winning source, then retires that source. It is the responding end of the level-request / IDENT protocol the interrupt controller initiates.

## Interface
- NSRC, 4: number of local sources (1..8)
- LEVEL, 4'd11: interrupt level this block answers
- IDBASE, 8'h00: ident code of source 0; source i answers IDBASE+i (8-bit, wraps mod 256)
- MCLK  in  1  system clock, all state on rising edge
- RESETN  in  1  asynchronous active-low reset
- SRC_REQ  in  NSRC  per-source request lines, rising edge sets pending
- SRC_CLR  in  NSRC  per-source pending clear (level)
- ENABLE  in  1  level enable
- IDENT  in  1  IDENT cycle in progress (level, held by initiator)
- IDLEV  in  4  level being identified
- PI  in  1  daisy-chain priority in (1 = may respond)
- PO  out  1  daisy-chain priority out
- INTRQ  out  1  level request toward controller
- IDVALID  out  1  IDCODE valid
- IDCODE  out  8  ident code of served source
- PEND  out  NSRC  pending bits
- SERVED  out  NSRC  one-cycle pulse, source retired

## Operation
- Edge detect: SRC_REQ registered; pending[i] set when SRC_REQ[i]=1 and previous=0.
- Pending clear by SRC_CLR[i] or by retirement in DONE; a new edge in the same cycle as any clear wins (pending stays 1).
- INTRQ register = ENABLE & |PEND.
- claim = IDENT & (IDLEV==LEVEL) & PI & ENABLE & |PEND.
- FSM states IDLE, PASS, LATCH, DRIVE, DONE:
  - IDLE: claim -> LATCH (capture winner index); IDENT & IDLEV==LEVEL & !claim -> PASS; else stay.
  - PASS: stay while IDENT; IDENT=0 -> IDLE.
  - LATCH: IDENT=0 -> IDLE (abort, pending kept); else -> DRIVE.
  - DRIVE: IDVALID=1, IDCODE=IDBASE+winner; IDENT=0 -> DONE.
  - DONE: clear pending[winner], SERVED[winner]=1 -> IDLE.
- PO combinational: PI & !claim in IDLE; PI in PASS; 0 in LATCH/DRIVE/DONE.
- Winner frozen from LATCH to DONE; SRC_CLR or ENABLE drop during LATCH/DRIVE does not abort the cycle.
- Winner selection: fixed priority, lowest index wins.
- IDCODE 0 whenever IDVALID=0.

## Timing
- Reset: state IDLE; PEND, INTRQ, IDVALID, IDCODE, SERVED, edge registers all 0; PO = PI & !claim (combinational).
- SRC_REQ rise sampled at edge n -> PEND at n+1 -> INTRQ at n+2.
- IDENT/IDLEV sampled at edge k in IDLE -> LATCH after k, DRIVE after k+1: IDVALID visible 2 cycles after IDENT sampled.
- IDENT low sampled in DRIVE at edge m -> DONE after m, IDVALID low same cycle; SERVED pulse and pending clear at edge m+1; INTRQ updates at m+2.
- IDENT held by initiator until IDVALID seen; block never deasserts IDVALID while IDENT is high.
- Back-to-back IDENT: new IDENT is accepted only from IDLE; IDENT high during DONE is taken on the following IDLE cycle.

## Configuration
- CGA_INTR_ROUND_ROBIN_EN defined: winner is the first pending index at or above a rotating pointer, wrapping; pointer <= winner+1 (mod NSRC) in DONE, reset 0. Aborted cycles leave the pointer unchanged.
- Undefined: fixed lowest-index priority, no pointer register.

## Structure
- Package cga_intr_pkg: FSM state enum, level width constant (4), ident code width constant (8).
- Sub-module cga_intr_prio_pick: combinational pending-vector + pointer -> winner index + any flag; pointer input tied to 0 without the macro.

## Test plan
- Single source: SRC_REQ[2] pulse, ENABLE=1 -> PEND=4'b0100, INTRQ=1; IDENT with IDLEV=11, PI=1 -> IDVALID after 2 cycles, IDCODE=8'h02, PO=0; drop IDENT -> SERVED=4'b0100, PEND=0, INTRQ=0.
- Priority: pend sources 1 and 3 -> first IDENT gives IDCODE=8'h01, second gives 8'h03; with CGA_INTR_ROUND_ROBIN_EN, pend 0,1 serviced 0, re-pend 0 -> next gives 8'h01.
- Pass-through: PI=0 or IDLEV=5 or PEND=0 -> IDVALID stays 0, PO follows PI, PEND unchanged.
- Collision: SRC_REQ[0] edge in the same cycle as SRC_CLR[0] and in the DONE cycle retiring source 0 -> PEND[0]=1 afterwards.
- Abort/reset: IDENT dropped in LATCH -> IDLE, PEND kept, no SERVED; RESETN low during DRIVE -> IDVALID=0, PEND=0 immediately.
